// File: rtl/lcd_fill_rect.sv
// Rectangle-fill byte generator for the ST7735 write path: emits CASET/RASET/RAMWR
// followed by W*H RGB565 pixels over the 9-bit data / en_write / wr_done handshake.
`timescale 1ns/1ps
module lcd_fill_rect #(
    parameter int X_OFFSET = 2,
    parameter int Y_OFFSET = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        fill_start,
    input  logic [8:0]  x_start,
    input  logic [8:0]  y_start,
    input  logic [8:0]  x_end,
    input  logic [8:0]  y_end,
    input  logic [15:0] color,
    input  logic        wr_done,
    output logic [8:0]  fill_data,
    output logic        en_write_fill,
    output logic        fill_busy,
    output logic        fill_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_ADV   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Byte index 11 marks the pixel phase; lo_q selects the colour half.
    localparam logic [3:0] PIX_IDX = 4'd11;

    logic [2:0]  state_q, state_d;
    logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [15:0] color_q, color_d;
    logic [9:0]  w_q, w_d, h_q, h_d;
    logic [8:0]  col_q, col_d, row_q, row_d;
    logic [3:0]  idx_q, idx_d;
    logic        lo_q, lo_d;
    logic [8:0]  data_q, data_d;
    logic        en_q, en_d, busy_q, busy_d, done_q, done_d;
    logic        last_s;

    logic [15:0] xs16_s, xe16_s, ys16_s, ye16_s;

    assign xs16_s = {7'd0, xs_q} + X_OFFSET[15:0];
    assign xe16_s = {7'd0, xe_q} + X_OFFSET[15:0];
    assign ys16_s = {7'd0, ys_q} + Y_OFFSET[15:0];
    assign ye16_s = {7'd0, ye_q} + Y_OFFSET[15:0];

    function automatic logic [8:0] byte_sel(
        input logic [3:0]  idx,
        input logic        lo,
        input logic [15:0] xs,
        input logic [15:0] xe,
        input logic [15:0] ys,
        input logic [15:0] ye,
        input logic [15:0] col
    );
        logic [8:0] b;
        case (idx)
            4'd0:    b = {1'b0, 8'h2A};
            4'd1:    b = {1'b1, xs[15:8]};
            4'd2:    b = {1'b1, xs[7:0]};
            4'd3:    b = {1'b1, xe[15:8]};
            4'd4:    b = {1'b1, xe[7:0]};
            4'd5:    b = {1'b0, 8'h2B};
            4'd6:    b = {1'b1, ys[15:8]};
            4'd7:    b = {1'b1, ys[7:0]};
            4'd8:    b = {1'b1, ye[15:8]};
            4'd9:    b = {1'b1, ye[7:0]};
            4'd10:   b = {1'b0, 8'h2C};
            4'd11:   b = lo ? {1'b1, col[7:0]} : {1'b1, col[15:8]};
            default: b = 9'd0;
        endcase
        return b;
    endfunction

    // Next-state logic for the FSM, counters and registered outputs.
    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        xe_d    = xe_q;
        ys_d    = ys_q;
        ye_d    = ye_q;
        color_d = color_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        row_d   = row_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        data_d  = data_q;
        en_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        last_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    xs_d    = x_start;
                    xe_d    = x_end;
                    ys_d    = y_start;
                    ye_d    = y_end;
                    color_d = color;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if ((xe_q < xs_q) || (ye_q < ys_q)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    w_d     = {1'b0, xe_q} - {1'b0, xs_q} + 10'd1;
                    h_d     = {1'b0, ye_q} - {1'b0, ys_q} + 10'd1;
                    col_d   = 9'd0;
                    row_d   = 9'd0;
                    idx_d   = 4'd0;
                    lo_d    = 1'b0;
                    data_d  = byte_sel(4'd0, 1'b0, xs16_s, xe16_s, ys16_s, ye16_s, color_q);
                    en_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wr_done) begin
                    state_d = S_ADV;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ADV: begin
                if (idx_q != PIX_IDX) begin
                    idx_d = idx_q + 4'd1;
                    lo_d  = 1'b0;
                end else if (!lo_q) begin
                    lo_d = 1'b1;
                end else begin
                    lo_d = 1'b0;
                    if ({1'b0, col_q} == (w_q - 10'd1)) begin
                        col_d = 9'd0;
                        if ({1'b0, row_q} == (h_q - 10'd1)) begin
                            last_s = 1'b1;
                        end else begin
                            row_d = row_q + 9'd1;
                        end
                    end else begin
                        col_d = col_q + 9'd1;
                    end
                end
                if (last_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    data_d  = byte_sel(idx_d, lo_d, xs16_s, xe16_s, ys16_s, ye16_s, color_q);
                    en_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and output registers with asynchronous abort.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            xs_q    <= 9'd0;
            xe_q    <= 9'd0;
            ys_q    <= 9'd0;
            ye_q    <= 9'd0;
            color_q <= 16'd0;
            w_q     <= 10'd0;
            h_q     <= 10'd0;
            col_q   <= 9'd0;
            row_q   <= 9'd0;
            idx_q   <= 4'd0;
            lo_q    <= 1'b0;
            data_q  <= 9'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            xe_q    <= xe_d;
            ys_q    <= ys_d;
            ye_q    <= ye_d;
            color_q <= color_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fill_data     = data_q;
    assign en_write_fill = en_q;
    assign fill_busy     = busy_q;
    assign fill_done     = done_q;

endmodule

// File: tb/tb_lcd_fill_rect.sv
// Directed bench for lcd_fill_rect with a writer model answering wr_done 4 cycles after each request.
`timescale 1ns/1ps
module tb_lcd_fill_rect;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        fill_start = 1'b0;
    logic [8:0]  x_start = 9'd0, y_start = 9'd0, x_end = 9'd0, y_end = 9'd0;
    logic [15:0] color = 16'd0;
    logic        wr_done;
    logic [8:0]  fill_data;
    logic        en_write_fill, fill_busy, fill_done;

    logic        wr_done_m = 1'b0;
    logic        wd_force = 1'b0;
    assign wr_done = wr_done_m | wd_force;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wd_cnt = 0, en_cnt = 0, done_cnt = 0, busy_gap = 0, min_gap = 1000;
    int first_en_cyc = 0, last_en_cyc = 0, done_cyc = 0, start_cyc = 0;
    logic [8:0] q[$];

    lcd_fill_rect #(.X_OFFSET(2), .Y_OFFSET(3)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .fill_start   (fill_start),
        .x_start      (x_start),
        .y_start      (y_start),
        .x_end        (x_end),
        .y_end        (y_end),
        .color        (color),
        .wr_done      (wr_done),
        .fill_data    (fill_data),
        .en_write_fill(en_write_fill),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Writer model and stream monitor, evaluated 1 ns after each edge.
    always @(posedge sys_clk) begin
        #1;
        wr_done_m = 1'b0;
        if (sys_rst) begin
            wd_cnt = 0;
        end else begin
            if (wd_cnt > 0) begin
                wd_cnt--;
                if (wd_cnt == 0) wr_done_m = 1'b1;
            end
            if (en_write_fill) begin
                q.push_back(fill_data);
                if (en_cnt == 0) first_en_cyc = cyc;
                else if (cyc - last_en_cyc < min_gap) min_gap = cyc - last_en_cyc;
                last_en_cyc = cyc;
                en_cnt++;
                wd_cnt = 4;
            end
            if (fill_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (en_cnt > 0 && done_cnt == 0 && !fill_busy) busy_gap++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic [8:0] xs, input logic [8:0] xe,
                               input logic [8:0] ys, input logic [8:0] ye,
                               input logic [15:0] c);
        @(posedge sys_clk); #3;
        x_start = xs; x_end = xe; y_start = ys; y_end = ye; color = c;
        fill_start = 1'b1;
        @(posedge sys_clk); #3;
        fill_start = 1'b0;
    endtask

    task automatic start_fill(input logic [8:0] xs, input logic [8:0] xe,
                              input logic [8:0] ys, input logic [8:0] ye,
                              input logic [15:0] c);
        @(posedge sys_clk); #3;
        q.delete();
        en_cnt = 0; done_cnt = 0; busy_gap = 0; min_gap = 1000;
        x_start = xs; x_end = xe; y_start = ys; y_end = ye; color = c;
        fill_start = 1'b1;
        start_cyc = cyc;
        @(posedge sys_clk); #3;
        fill_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge sys_clk); #3;
            n++;
        end
        check(tag, (done_cnt > 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    logic [8:0] exp1 [15] = '{9'h02A, 9'h100, 9'h102, 9'h100, 9'h103, 9'h02B, 9'h100, 9'h103,
                              9'h100, 9'h103, 9'h02C, 9'h1F8, 9'h100, 9'h1F8, 9'h100};

    initial begin
        int bad;
        int n;
        // Reset state
        repeat (3) @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;
        check("rst_data", {23'd0, fill_data}, 32'd0);
        check("rst_en", {31'd0, en_write_fill}, 32'd0);
        check("rst_busy", {31'd0, fill_busy}, 32'd0);
        check("rst_done", {31'd0, fill_done}, 32'd0);

        // Two-pixel fill, reference stream
        start_fill(9'd0, 9'd1, 9'd0, 9'd0, 16'hF800);
        wait_done("t1_done", 500);
        check("t1_count", q.size(), 32'd15);
        for (int i = 0; i < 15; i++) check($sformatf("t1_byte%0d", i), (i < q.size()) ? {23'd0, q[i]} : 32'hFFFF, {23'd0, exp1[i]});
        check("t1_first_en_lat", first_en_cyc - start_cyc, 32'd2);
        repeat (3) @(posedge sys_clk);
        #3;
        check("t1_done_once", done_cnt, 32'd1);

        // 3x2 window
        start_fill(9'd10, 9'd12, 9'd5, 9'd6, 16'h1234);
        wait_done("t2_done", 1000);
        check("t2_count", en_cnt, 32'd23);
        if (q.size() == 23) begin
            check("t2_xs_lo", {23'd0, q[2]}, 32'h10C);
            check("t2_xe_lo", {23'd0, q[4]}, 32'h10E);
            check("t2_ys_lo", {23'd0, q[7]}, 32'h108);
            check("t2_ye_lo", {23'd0, q[9]}, 32'h109);
        end
        bad = 0;
        for (int i = 11; i < q.size(); i++)
            if (q[i] !== (((i - 11) % 2 == 0) ? 9'h112 : 9'h134)) bad++;
        check("t2_pixel_bytes", bad, 32'd0);
        check("t2_busy_gap", busy_gap, 32'd0);
        check("t2_min_spacing_ge3", (min_gap >= 3) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) @(posedge sys_clk);
        #3;
        check("t2_done_once", done_cnt, 32'd1);

        // Inverted window
        start_fill(9'd5, 9'd4, 9'd0, 9'd0, 16'hFFFF);
        wait_done("t3_done", 20);
        check("t3_done_lat", done_cyc - start_cyc, 32'd2);
        repeat (5) @(posedge sys_clk);
        #3;
        check("t3_no_bytes", en_cnt, 32'd0);
        check("t3_busy_low", {31'd0, fill_busy}, 32'd0);

        // Restart attempts during a fill are ignored
        start_fill(9'd0, 9'd1, 9'd0, 9'd0, 16'hF800);
        repeat (10) @(posedge sys_clk);
        drive_start(9'd100, 9'd200, 9'd50, 9'd60, 16'h0F0F);
        wait_done("t4_done", 500);
        check("t4_count", q.size(), 32'd15);
        bad = 0;
        for (int i = 0; i < q.size() && i < 15; i++) if (q[i] !== exp1[i]) bad++;
        check("t4_stream_unchanged", bad, 32'd0);
        repeat (20) @(posedge sys_clk);
        #3;
        check("t4_no_second_fill", en_cnt, 32'd15);
        start_fill(9'd0, 9'd0, 9'd0, 9'd0, 16'hABCD);
        wait_done("t4b_done", 500);
        check("t4b_count", q.size(), 32'd13);
        if (q.size() == 13) begin
            check("t4b_hi", {23'd0, q[11]}, 32'h1AB);
            check("t4b_lo", {23'd0, q[12]}, 32'h1CD);
        end

        // Asynchronous reset in the pixel phase
        start_fill(9'd0, 9'd3, 9'd0, 9'd3, 16'h5A5A);
        n = 0;
        while (q.size() < 14 && n < 500) begin
            @(posedge sys_clk); #3;
            n++;
        end
        check("t5_reached_pixels", (q.size() >= 14) ? 32'd1 : 32'd0, 32'd1);
        sys_rst = 1'b1;
        #1;
        check("t5_rst_data", {23'd0, fill_data}, 32'd0);
        check("t5_rst_en", {31'd0, en_write_fill}, 32'd0);
        check("t5_rst_busy", {31'd0, fill_busy}, 32'd0);
        check("t5_rst_done", {31'd0, fill_done}, 32'd0);
        @(posedge sys_clk); #3;
        sys_rst = 1'b0;
        q.delete();
        en_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            wd_force = 1'b1;
            @(posedge sys_clk); #3;
            wd_force = 1'b0;
            @(posedge sys_clk); #3;
        end
        repeat (10) @(posedge sys_clk);
        #3;
        check("t5_no_stray_bytes", en_cnt, 32'd0);
        check("t5_no_stray_done", done_cnt, 32'd0);
        check("t5_idle_busy", {31'd0, fill_busy}, 32'd0);

        // Full-width row at the coordinate limit
        start_fill(9'd0, 9'd511, 9'd511, 9'd511, 16'hC3A5);
        wait_done("t6_done", 10000);
        check("t6_count", q.size(), 32'd1035);
        if (q.size() == 1035) begin
            check("t6_xs_hi", {23'd0, q[1]}, 32'h100);
            check("t6_xs_lo", {23'd0, q[2]}, 32'h102);
            check("t6_xe_hi", {23'd0, q[3]}, 32'h102);
            check("t6_xe_lo", {23'd0, q[4]}, 32'h101);
            check("t6_ys_hi", {23'd0, q[6]}, 32'h102);
            check("t6_ye_lo", {23'd0, q[9]}, 32'h102);
            check("t6_last_hi", {23'd0, q[1033]}, 32'h1C3);
            check("t6_last_lo", {23'd0, q[1034]}, 32'h1A5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_fill_rect.md
Name: lcd_fill_rect

Overview:
- Rectangle-fill command generator for the ST7735 SPI LCD path.
- Takes a window (x_start..x_end, y_start..y_end) and a 16-bit RGB565 colour, then emits the ST7735 byte stream: CASET, RASET, RAMWR, then W*H pixels.
- Uses the same 9-bit data / en_write / wr_done byte handshake as the existing char-display source.
- Sits upstream of the write-source mux, in parallel with the char-display source. Used for screen clear and status-bar background blocks.

Parameters:
- X_OFFSET, 2: panel column offset added to both x coordinates before transmission.
- Y_OFFSET, 3: panel row offset added to both y coordinates before transmission.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- fill_start  in  1  one-cycle start pulse; sampled only in IDLE.
- x_start  in  9  first column (inclusive); captured at accepted fill_start.
- y_start  in  9  first row (inclusive); captured at accepted fill_start.
- x_end  in  9  last column (inclusive); captured at accepted fill_start.
- y_end  in  9  last row (inclusive); captured at accepted fill_start.
- color  in  16  RGB565 fill colour; captured at accepted fill_start.
- wr_done  in  1  one-cycle pulse from the SPI writer: current byte shifted out.
- fill_data  out  9  bit8 = 0 command / 1 data; bits[7:0] = byte.
- en_write_fill  out  1  one-cycle request to write fill_data.
- fill_busy  out  1  high from the cycle after an accepted start until fill_done.
- fill_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: fill_data = 0, en_write_fill = 0, fill_busy = 0, fill_done = 0. All counters 0, FSM in IDLE.
- Reset is asynchronous. Asserting it mid-fill aborts immediately; no further bytes are emitted after release.
- FSM states: IDLE, CHECK, ISSUE, WAIT, ADV, DONE.
- IDLE:
  - On fill_start, latch all inputs, go to CHECK, set fill_busy.
  - fill_start while busy is ignored; the latched inputs do not change.
- CHECK (1 cycle):
  - If x_end < x_start or y_end < y_start, go to DONE with no bytes sent.
  - Otherwise compute XS = x_start + X_OFFSET, XE = x_end + X_OFFSET, YS, YE likewise, each 16-bit zero-extended.
  - Clear the byte index and pixel counters, go to ISSUE.
- Byte sequence (index 0..10, then pixels):
  - 0: {0, 0x2A}.
  - 1–4: {1, XS[15:8]}, {1, XS[7:0]}, {1, XE[15:8]}, {1, XE[7:0]}.
  - 5: {0, 0x2B}.
  - 6–9: YS, YE bytes, same order as XS/XE.
  - 10: {0, 0x2C}.
  - Then for each pixel, row-major: {1, color[15:8]}, {1, color[7:0]}.
- Byte count: 11 + 2*W*H, where W = x_end - x_start + 1 and H = y_end - y_start + 1.
- ISSUE:
  - Drive fill_data, pulse en_write_fill for exactly 1 cycle, go to WAIT.
  - fill_data stays stable from ISSUE until the cycle after wr_done.
- WAIT:
  - Hold until wr_done, then go to ADV.
  - wr_done arriving in any other state is ignored.
- ADV (1 cycle): advance to the next byte.
  - Pixel phase: the hi/lo flag toggles. After the lo byte, the column counter increments. At column = W-1 it wraps to 0 and the row counter increments.
  - After the lo byte of pixel (W-1, H-1), go to DONE. Otherwise go to ISSUE.
- Issue spacing: consecutive en_write_fill pulses are at least 3 cycles apart (ISSUE, WAIT ≥ 1, ADV).
- First en_write_fill: exactly 2 cycles after the accepted fill_start cycle (CHECK, then ISSUE).
- DONE: fill_done = 1 for 1 cycle, fill_busy drops in the same cycle, return to IDLE.
  - A fill_start in the DONE cycle is ignored.
  - A fill_start in the following cycle is accepted.
- Counters: column/row counters are 9 bits, W and H are 10 bits.
  - Full-range window 0..511 must not overflow.
- Coordinate add: the offset add is 16-bit, so there is no wrap at 9-bit.

Test Plan:
- Reset, then fill_start with x 0..1, y 0..0, color 0xF800. Writer model answers wr_done 4 cycles after each en_write:
  - exactly 15 bytes emitted: 0x02A, 0x100, 0x102, 0x100, 0x103, 0x02B, 0x100, 0x103, 0x100, 0x103, 0x02C, 0x1F8, 0x100, 0x1F8, 0x100.
  - then one fill_done pulse.
- Window x 10..12, y 5..6, color 0x1234:
  - 11 + 12 = 23 en_write_fill pulses, pixel bytes alternating 0x112 / 0x134.
  - fill_busy high throughout, fill_done once.
- Inverted window x_start = 5, x_end = 4:
  - no en_write_fill.
  - fill_done exactly 2 cycles after fill_start.
- fill_start re-pulsed with different coords during a fill:
  - stream unchanged.
  - a second fill runs only after a start given post-done.
- sys_rst asserted mid-pixel-phase:
  - all outputs 0 immediately.
  - after release, stray wr_done pulses produce no bytes.
- Boundary coords x_end = 511 with X_OFFSET = 2: XE bytes are 0x102, 0x101 (513).
